// File: rtl/elastic_pipe_reg.sv
// rtl/elastic_pipe_reg.sv - elastic valid/ready register chain with flush, freeze and occupancy count
// PIPE_SKID_EN selects two-entry slots with registered ready; undefined gives single-entry slots.
module elastic_pipe_reg #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             freeze,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       occupancy
);

`ifdef PIPE_SKID_EN
  logic [STAGES-1:0] skid_valid;
  logic [WIDTH-1:0]  skid_data [STAGES];
`endif
  logic [STAGES-1:0] main_valid;
  logic [WIDTH-1:0]  main_data [STAGES];
  logic [WIDTH-1:0]  up_data   [STAGES];
  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] accept;
  logic [STAGES-1:0] take;
  logic              in_xfer;
  logic              out_xfer;

  // rdy[k] is slot k's ready toward its upstream; rdy[STAGES] is the downstream consumer.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
`ifdef PIPE_SKID_EN
      rdy[k] = ~skid_valid[k];
`else
      rdy[k] = ~main_valid[k] | rdy[k+1];
`endif
    end
  end

  always_comb begin
    up_data[0] = in_data;
    for (int k = 1; k < STAGES; k++) up_data[k] = main_data[k-1];
    for (int k = 0; k < STAGES; k++) take[k] = main_valid[k] & rdy[k+1] & ~freeze;
    accept[0] = in_valid & rdy[0] & ~freeze;
    for (int k = 1; k < STAGES; k++) accept[k] = take[k-1];
  end

  assign in_ready  = rdy[0] & ~freeze;
  assign out_valid = main_valid[STAGES-1] & ~freeze;
  assign out_data  = main_data[STAGES-1];
  assign in_xfer   = accept[0];
  assign out_xfer  = take[STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= '0;
`ifdef PIPE_SKID_EN
      skid_valid <= '0;
      for (int k = 0; k < STAGES; k++) skid_data[k] <= '0;
`endif
      for (int k = 0; k < STAGES; k++) main_data[k] <= '0;
      occupancy <= '0;
    end else if (flush) begin
      // Only the valid bits are discarded; payload registers keep their contents.
      main_valid <= '0;
`ifdef PIPE_SKID_EN
      skid_valid <= '0;
`endif
      occupancy <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
`ifdef PIPE_SKID_EN
        if (take[k] && skid_valid[k]) begin
          main_data[k]  <= skid_data[k];
          skid_valid[k] <= 1'b0;
        end else if (accept[k] && main_valid[k] && !take[k]) begin
          skid_data[k]  <= up_data[k];
          skid_valid[k] <= 1'b1;
        end else if (accept[k]) begin
          main_data[k]  <= up_data[k];
          main_valid[k] <= 1'b1;
        end else if (take[k]) begin
          main_valid[k] <= 1'b0;
        end
`else
        if (accept[k]) begin
          main_data[k]  <= up_data[k];
          main_valid[k] <= 1'b1;
        end else if (take[k]) begin
          main_valid[k] <= 1'b0;
        end
`endif
      end
      occupancy <= occupancy + 4'(in_xfer) - 4'(out_xfer);
    end
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb/tb_elastic_pipe_reg.sv - directed self-checking bench for elastic_pipe_reg (STAGES=3, WIDTH=32)
module tb_elastic_pipe_reg;
  localparam int WIDTH  = 32;
  localparam int STAGES = 3;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2 * STAGES;
`else
  localparam int CAP = STAGES;
`endif
  localparam int HELD = (CAP < 4) ? CAP : 4;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             flush     = 1'b0;
  logic             freeze    = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       occupancy;
  int               vectors     = 0;
  int               miscompares = 0;

  always #5 clk = ~clk;

  elastic_pipe_reg #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + WIDTH'(i);
      next_cycle();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    int found;
    logic [WIDTH-1:0] got;
    #1 rst = 1'b0;
    #2;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    out_ready = 1'b0;
    load(HELD, 32'h10);
    vectors++; if (occupancy !== 4'(HELD)) begin miscompares++; $display("FAIL pre_reset_occupancy: got %0d want %0d", occupancy, HELD); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL midreset_out_data: got %h want 0", out_data); end
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL midreset_occupancy: got %0d want 0", occupancy); end
    next_cycle();
    rst = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    next_cycle();
    in_valid  = 1'b1;
    in_data   = 32'h77;
    out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    found = -1;
    got   = '0;
    for (int c = 1; c <= 10; c++) begin
      if (out_valid && found < 0) begin found = c; got = out_data; end
      next_cycle();
    end
    vectors++; if (found != STAGES) begin miscompares++; $display("FAIL post_reset_latency: got %0d want %0d", found, STAGES); end
    vectors++; if (got !== 32'h77) begin miscompares++; $display("FAIL post_reset_data: got %h want 00000077", got); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int c = 0; c < 16 + STAGES + 2; c++) begin
      if (c < 16) begin in_valid = 1'b1; in_data = WIDTH'(c + 1); end
      else in_valid = 1'b0;
      #1;
      if (c < 16) begin
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready c=%0d: got %b want 1", c, in_ready); end
      end
      vectors++;
      if (c >= STAGES && c < STAGES + 16) begin
        if (out_valid !== 1'b1 || out_data !== WIDTH'(c - STAGES + 1)) begin
          miscompares++; $display("FAIL stream_out c=%0d: got v=%b d=%h want v=1 d=%h", c, out_valid, out_data, WIDTH'(c - STAGES + 1));
        end
      end else if (out_valid !== 1'b0) begin
        miscompares++; $display("FAIL stream_idle c=%0d: got v=%b want 0", c, out_valid);
      end
      next_cycle();
    end
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL stream_occupancy: got %0d want 0", occupancy); end
  endtask

  task automatic test_back_pressure();
    int acc;
    int got;
    int rise;
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_data  = 32'h100 + acc;
      #1;
      if (!in_ready) break;
      acc++;
      next_cycle();
    end
    vectors++; if (acc != CAP) begin miscompares++; $display("FAIL bp_accepted: got %0d want %0d", acc, CAP); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    vectors++; if (occupancy !== 4'(CAP)) begin miscompares++; $display("FAIL bp_occupancy: got %0d want %0d", occupancy, CAP); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    got  = 0;
    rise = -1;
    for (int e = 0; e < 15; e++) begin
      #1;
      if (in_ready && rise < 0) rise = e;
      if (out_valid) begin
        vectors++; if (out_data !== 32'h100 + got) begin miscompares++; $display("FAIL bp_drain_data #%0d: got %h want %h", got, out_data, 32'h100 + got); end
        got++;
      end
      next_cycle();
    end
`ifdef PIPE_SKID_EN
    vectors++; if (rise != STAGES) begin miscompares++; $display("FAIL bp_ready_return: got %0d want %0d", rise, STAGES); end
`else
    vectors++; if (rise != 0) begin miscompares++; $display("FAIL bp_ready_comb: got %0d want 0", rise); end
`endif
    vectors++; if (got != CAP) begin miscompares++; $display("FAIL bp_drain_count: got %0d want %0d", got, CAP); end
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL bp_end_occupancy: got %0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    int found;
    logic [WIDTH-1:0] got;
    out_ready = 1'b0;
    load(HELD, 32'h200);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    #1;
    vectors++; if (in_ready !== (HELD < CAP)) begin miscompares++; $display("FAIL flush_in_ready: got %b want %b", in_ready, HELD < CAP); end
    next_cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL flush_occupancy: got %0d want 0", occupancy); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_leak c=%0d: got v=%b d=%h want v=0", c, out_valid, out_data); end
      next_cycle();
    end
    in_valid = 1'b1;
    in_data  = 32'h55;
    next_cycle();
    in_valid = 1'b0;
    found = -1;
    got   = '0;
    for (int c = 1; c <= 10; c++) begin
      if (out_valid && found < 0) begin found = c; got = out_data; end
      next_cycle();
    end
    vectors++; if (found != STAGES) begin miscompares++; $display("FAIL post_flush_latency: got %0d want %0d", found, STAGES); end
    vectors++; if (got !== 32'h55) begin miscompares++; $display("FAIL post_flush_data: got %h want 00000055", got); end
  endtask

  task automatic test_freeze();
    int got;
    out_ready = 1'b0;
    load(2, 32'h300);
    repeat (4) next_cycle();
    vectors++; if (out_valid !== 1'b1 || out_data !== 32'h300) begin miscompares++; $display("FAIL prefreeze_out: got v=%b d=%h want v=1 d=00000300", out_valid, out_data); end
    freeze    = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hBAD;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL freeze_in_ready c=%0d: got %b want 0", c, in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL freeze_out_valid c=%0d: got %b want 0", c, out_valid); end
      vectors++; if (out_data !== 32'h300) begin miscompares++; $display("FAIL freeze_out_data c=%0d: got %h want 00000300", c, out_data); end
      vectors++; if (occupancy !== 4'd2) begin miscompares++; $display("FAIL freeze_occupancy c=%0d: got %0d want 2", c, occupancy); end
      next_cycle();
    end
    freeze   = 1'b0;
    in_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid) begin
        vectors++; if (out_data !== 32'h300 + got) begin miscompares++; $display("FAIL unfreeze_data #%0d: got %h want %h", got, out_data, 32'h300 + got); end
        got++;
      end
      next_cycle();
    end
    vectors++; if (got != 2) begin miscompares++; $display("FAIL unfreeze_count: got %0d want 2", got); end
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL unfreeze_occupancy: got %0d want 0", occupancy); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_freeze();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
